// File: rtl/dff_pkg.sv
// Shared limits and defaults for the dff register-stage primitive.
package dff_pkg;

    localparam int unsigned DFF_MAX_WIDTH  = 1024;
    localparam int unsigned DFF_MAX_STAGES = 16;
    localparam int unsigned DFF_DEF_WIDTH  = 1;
    localparam int unsigned DFF_DEF_STAGES = 1;

endpackage

// File: rtl/dff_if.sv
// Data bundle for dff: master drives d, slave returns the delayed q.
interface dff_if
    import dff_pkg::*;
#(
    parameter int unsigned WIDTH = DFF_DEF_WIDTH
);

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (output d, input q);
    modport slave (input d, output q);

endinterface

// File: rtl/dff_stage.sv
// One WIDTH-bit register with async active-high reset to RESET_VAL.
module dff_stage
    import dff_pkg::*;
#(
    parameter int unsigned      WIDTH     = DFF_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dff.sv
// Parameterised D register pipeline: STAGES cascaded dff_stage registers.
module dff
    import dff_pkg::*;
#(
    parameter int unsigned WIDTH     = DFF_DEF_WIDTH,
    parameter int unsigned STAGES    = DFF_DEF_STAGES,
    parameter              RESET_VAL = 0
) (
    input  logic  i_clk,
    input  logic  i_rst,
    dff_if.slave  bus
);

    localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);

    if (WIDTH < 1 || WIDTH > DFF_MAX_WIDTH) begin : g_bad_width
        $error("dff: WIDTH=%0d outside 1..%0d", WIDTH, DFF_MAX_WIDTH);
    end

    if (STAGES < 1 || STAGES > DFF_MAX_STAGES) begin : g_bad_stages
        $error("dff: STAGES=%0d outside 1..%0d", STAGES, DFF_MAX_STAGES);
    end

    // Any set bit at or above WIDTH means the reset value cannot fit.
    if ((RESET_VAL >> WIDTH) != 0) begin : g_bad_rv
        $error("dff: RESET_VAL wider than WIDTH=%0d", WIDTH);
    end

    logic [WIDTH-1:0] w_s [STAGES];

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        logic [WIDTH-1:0] w_d;

        if (g == 0) begin : g_head
            assign w_d = bus.d;
        end else begin : g_tail
            assign w_d = w_s[g-1];
        end

        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RV)
        ) u_stage (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_d   (w_d),
            .o_q   (w_s[g])
        );
    end

    assign bus.q = w_s[STAGES-1];

`ifndef SYNTHESIS
    logic r_rst_seen;

    always @(posedge i_rst) begin
        r_rst_seen <= 1'b1;
    end

    always @(negedge i_clk) begin
        if (i_rst) begin
            assert (bus.q == RV)
            else $error("dff: q=%h not reset value during reset", bus.q);
        end else if (r_rst_seen === 1'b1) begin
            assert (!$isunknown(bus.q))
            else $error("dff: q unknown after reset");
        end
    end
`endif

endmodule

// File: tb/tb_dff.sv
// Directed bench: default plain flop and an 8-bit, 3-stage, 8'hA5 pipeline.
module tb_dff;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_checks;
    int   n_errors;

    dff_if #(.WIDTH(1)) bus_a ();
    dff_if #(.WIDTH(8)) bus_b ();

    dff u_a (
        .i_clk (clk),
        .i_rst (rst_a),
        .bus   (bus_a)
    );

    dff #(
        .WIDTH     (8),
        .STAGES    (3),
        .RESET_VAL (8'hA5)
    ) u_b (
        .i_clk (clk),
        .i_rst (rst_b),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic at(input int t);
        #(t - int'($time));
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_a     = 1'b0;
        rst_b     = 1'b0;
        bus_a.d   = 1'b0;
        bus_b.d   = 8'hFF;

        at(1);
        rst_a = 1'b1;
        rst_b = 1'b1;
        at(3);
        rst_a = 1'b0;
        at(4);
        chk("a_reset", {7'b0, bus_a.q}, 8'h00);
        chk("b_reset", bus_b.q, 8'hA5);

        // Basic capture on the default plain flop
        at(10);  bus_a.d = 1'b1;
        at(16);  chk("a_cap1", {7'b0, bus_a.q}, 8'h01);
        at(26);  bus_a.d = 1'b0;
        at(30);  chk("a_hold1", {7'b0, bus_a.q}, 8'h01);
        at(36);  chk("a_cap0", {7'b0, bus_a.q}, 8'h00);
        bus_a.d = 1'b1;
        at(41);  bus_a.d = 1'b0;
        at(46);  chk("a_glitch", {7'b0, bus_a.q}, 8'h00);
        at(50);  bus_a.d = 1'b1;
        at(56);  chk("a_held_c1", {7'b0, bus_a.q}, 8'h01);
        at(66);  chk("a_held_c2", {7'b0, bus_a.q}, 8'h01);
        at(76);  chk("a_held_c3", {7'b0, bus_a.q}, 8'h01);
        at(86);  chk("a_held_c4", {7'b0, bus_a.q}, 8'h01);
        at(90);  bus_a.d = 1'b0;
        at(96);  chk("a_held_end", {7'b0, bus_a.q}, 8'h00);

        // Async reset mid-period, then held across three edges
        at(98);  bus_a.d = 1'b1;
        at(106); chk("a_pre_rst", {7'b0, bus_a.q}, 8'h01);
        at(108); rst_a = 1'b1;
        at(109); chk("a_async_rst", {7'b0, bus_a.q}, 8'h00);
        at(116); chk("a_rst_e1", {7'b0, bus_a.q}, 8'h00);
        at(126); chk("a_rst_e2", {7'b0, bus_a.q}, 8'h00);
        at(136); chk("a_rst_e3", {7'b0, bus_a.q}, 8'h00);

        // Release on the edge itself: that edge still belongs to reset
        at(140);
        @(posedge clk);
        rst_a <= 1'b0;
        at(146); chk("a_rel_edge", {7'b0, bus_a.q}, 8'h00);
        at(156); chk("a_rel_next", {7'b0, bus_a.q}, 8'h01);
        at(165); rst_a = 1'b1;
        at(166); chk("a_rst_at_edge", {7'b0, bus_a.q}, 8'h00);
        chk("b_rst_held", bus_b.q, 8'hA5);

        // Three-stage pipeline
        at(172); rst_b = 1'b0; bus_b.d = 8'h01;
        at(176); chk("b_lat_e1", bus_b.q, 8'hA5);
        at(180); bus_b.d = 8'h02;
        at(186); chk("b_lat_e2", bus_b.q, 8'hA5);
        at(190); bus_b.d = 8'h03;
        at(196); chk("b_out_01", bus_b.q, 8'h01);
        at(200); bus_b.d = 8'h04;
        at(206); chk("b_out_02", bus_b.q, 8'h02);
        at(210); bus_b.d = 8'h05;
        at(216); chk("b_out_03", bus_b.q, 8'h03);

        // Reset with values still in flight
        at(218); rst_b = 1'b1;
        at(219); chk("b_mid_rst", bus_b.q, 8'hA5);
        at(222); rst_b = 1'b0; bus_b.d = 8'h77;
        at(226); chk("b_flush_e1", bus_b.q, 8'hA5);
        at(236); chk("b_flush_e2", bus_b.q, 8'hA5);
        at(246); chk("b_flush_e3", bus_b.q, 8'h77);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
